pwm_seq_ctrl: RTL and testbench

//   Sequencer for the SPI-configured PWM generator. Steps the PWM duty through a small

---
 rtl/pwm_seq_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_pwm_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_seq_ctrl
// Sequencer for the SPI-configured PWM generator. Steps the PWM duty through a
// small table written over SPI. Each step is held for a programmable number of
// PWM periods. A sequence starts on an SPI register pulse or on a rising edge
// of the external start pin.
//
// Ports
//   clk, rst_n    : system clock, asynchronous active-low reset
//   start_reg     : 1-cycle start pulse from an SPI register write
//   start_ext     : external start level (already synchronised to clk)
//   ext_start_en  : enables starting on a rising edge of start_ext
//   stop          : 1-cycle abort pulse
//   loop          : wrap to step 0 after the last step instead of finishing
//   hold          : PWM periods per step (0 behaves as 1)
//   last_idx      : index of the final step
//   wr_en/wr_addr/wr_data : sequence table write port
//   period_end    : 1-cycle pulse from the PWM counter at period wrap
//   pwm_en        : PWM generator enable
//   duty          : duty value to the PWM generator
//   busy          : sequence running
//   done          : 1-cycle pulse on normal completion
//   step          : current step index
// -----------------------------------------------------------------------------
module pwm_seq_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int RW    = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_reg,
    input  logic          start_ext,
    input  logic          ext_start_en,
    input  logic          stop,
    input  logic          loop,
    input  logic [RW-1:0] hold,
    input  logic [AW-1:0] last_idx,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          period_end,
    output logic          pwm_en,
    output logic [DW-1:0] duty,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;

    logic [DW-1:0] table_r [DEPTH];

    logic [AW-1:0] step_r;
    logic [AW-1:0] step_nx_s;
    logic [AW-1:0] step_inc_s;
    logic [DW-1:0] duty_r;
    logic [DW-1:0] duty_nx_s;
    logic [RW-1:0] hold_cnt_r;
    logic [RW-1:0] hold_cnt_nx_s;
    logic [RW-1:0] hold_reload_s;

    logic          pwm_en_r;
    logic          pwm_en_nx_s;
    logic          busy_r;
    logic          busy_nx_s;
    logic          done_r;
    logic          done_nx_s;

    logic          start_ext_q_r;
    logic          start_s;

    // A zero hold still lasts one period, so the reload value saturates at 0.
    assign hold_reload_s = (hold == {RW{1'b0}}) ? {RW{1'b0}} : (hold - RW'(1));
    assign step_inc_s    = step_r + AW'(1);

    // Start sources: register pulse or qualified rising edge of the external pin.
    assign start_s = start_reg | (ext_start_en & start_ext & ~start_ext_q_r);

    // Edge-detect register; resets high so a pin already high at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_ext_q_r <= 1'b1;
        end else begin
            start_ext_q_r <= start_ext;
        end
    end

    // Sequence table write port; writes are accepted in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (wr_en) begin
                table_r[wr_addr] <= wr_data;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            step_r     <= {AW{1'b0}};
            duty_r     <= {DW{1'b0}};
            hold_cnt_r <= {RW{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            step_r     <= step_nx_s;
            duty_r     <= duty_nx_s;
            hold_cnt_r <= hold_cnt_nx_s;
        end
    end

    // Next-state and datapath logic; priority is stop > period_end > start.
    always_comb begin
        state_nx_s    = state_r;
        step_nx_s     = step_r;
        duty_nx_s     = duty_r;
        hold_cnt_nx_s = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nx_s    = ST_RUN;
                    step_nx_s     = {AW{1'b0}};
                    duty_nx_s     = table_r[0];
                    hold_cnt_nx_s = hold_reload_s;
                end else begin
                    state_nx_s    = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nx_s    = ST_IDLE;
                    step_nx_s     = {AW{1'b0}};
                    duty_nx_s     = {DW{1'b0}};
                    hold_cnt_nx_s = {RW{1'b0}};
                end else if (period_end) begin
                    if (hold_cnt_r != {RW{1'b0}}) begin
                        hold_cnt_nx_s = hold_cnt_r - RW'(1);
                    end else if (step_r != last_idx) begin
                        step_nx_s     = step_inc_s;
                        duty_nx_s     = table_r[step_inc_s];
                        hold_cnt_nx_s = hold_reload_s;
                    end else if (loop) begin
                        step_nx_s     = {AW{1'b0}};
                        duty_nx_s     = table_r[0];
                        hold_cnt_nx_s = hold_reload_s;
                    end else begin
                        state_nx_s    = ST_FIN;
                        step_nx_s     = {AW{1'b0}};
                        duty_nx_s     = {DW{1'b0}};
                        hold_cnt_nx_s = {RW{1'b0}};
                    end
                end else begin
                    state_nx_s    = ST_RUN;
                end
            end
            ST_FIN: begin
                // FIN lasts exactly one cycle whether or not stop arrives.
                state_nx_s    = ST_IDLE;
                step_nx_s     = {AW{1'b0}};
                duty_nx_s     = {DW{1'b0}};
                hold_cnt_nx_s = {RW{1'b0}};
            end
            default: begin
                state_nx_s    = ST_IDLE;
                step_nx_s     = {AW{1'b0}};
                duty_nx_s     = {DW{1'b0}};
                hold_cnt_nx_s = {RW{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the status flags are registered alongside it.
    always_comb begin
        pwm_en_nx_s = 1'b0;
        busy_nx_s   = 1'b0;
        done_nx_s   = 1'b0;
        case (state_nx_s)
            ST_IDLE: begin
                pwm_en_nx_s = 1'b0;
                busy_nx_s   = 1'b0;
                done_nx_s   = 1'b0;
            end
            ST_RUN: begin
                pwm_en_nx_s = 1'b1;
                busy_nx_s   = 1'b1;
                done_nx_s   = 1'b0;
            end
            ST_FIN: begin
                pwm_en_nx_s = 1'b0;
                busy_nx_s   = 1'b0;
                done_nx_s   = 1'b1;
            end
            default: begin
                pwm_en_nx_s = 1'b0;
                busy_nx_s   = 1'b0;
                done_nx_s   = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            pwm_en_r <= pwm_en_nx_s;
            busy_r   <= busy_nx_s;
            done_r   <= done_nx_s;
        end
    end

    assign pwm_en = pwm_en_r;
    assign duty   = duty_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign step   = step_r;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_seq_ctrl
// Scoreboard bench: stimulus pushes the expected duty for each PWM period and
// the expected period count at each done pulse; a monitor running on the
// falling clock edge pops and compares whenever the DUT is running and
// period_end is presented, or whenever done pulses.
// -----------------------------------------------------------------------------
module tb_pwm_seq_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int RW    = 8;
    localparam int AW    = 2;

    logic          clk;
    logic          rst_n;
    logic          start_reg;
    logic          start_ext;
    logic          ext_start_en;
    logic          stop;
    logic          loop;
    logic [RW-1:0] hold;
    logic [AW-1:0] last_idx;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          period_end;
    logic          pwm_en;
    logic [DW-1:0] duty;
    logic          busy;
    logic          done;
    logic [AW-1:0] step;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_duty_q [$];
    int            exp_done_q [$];
    int            per_cnt    = 0;
    logic          busy_prev  = 1'b0;

    pwm_seq_ctrl #(.DW(DW), .DEPTH(DEPTH), .RW(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_reg    (start_reg),
        .start_ext    (start_ext),
        .ext_start_en (ext_start_en),
        .stop         (stop),
        .loop         (loop),
        .hold         (hold),
        .last_idx     (last_idx),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .period_end   (period_end),
        .pwm_en       (pwm_en),
        .duty         (duty),
        .busy         (busy),
        .done         (done),
        .step         (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares duty per period and the period count at each done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && !busy_prev) begin
                per_cnt = 0;
            end
            if (period_end && busy) begin
                per_cnt = per_cnt + 1;
                tests = tests + 1;
                if (exp_duty_q.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL period_duty: unexpected period, duty=%0d, none expected", duty);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_duty_q.pop_front();
                    if (duty !== e) begin
                        fails = fails + 1;
                        $display("FAIL period_duty: period %0d got %0d expected %0d", per_cnt, duty, e);
                    end
                end
            end
            if (done) begin
                tests = tests + 1;
                if (exp_done_q.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL done_pulse: unexpected done after %0d periods", per_cnt);
                end else begin
                    int e;
                    e = exp_done_q.pop_front();
                    if (per_cnt != e) begin
                        fails = fails + 1;
                        $display("FAIL done_pulse: got done after %0d periods expected %0d", per_cnt, e);
                    end
                end
            end
        end
        busy_prev = busy;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start_reg = 1'b1;
        cyc();
        start_reg = 1'b0;
    endtask

    task automatic pulse(input logic with_stop);
        period_end = 1'b1;
        stop       = with_stop;
        cyc();
        period_end = 1'b0;
        stop       = 1'b0;
        cyc();
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_reg = 1'b0; start_ext = 1'b0; ext_start_en = 1'b0;
        stop = 1'b0; loop = 1'b0; hold = 8'd0; last_idx = 2'd0;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0; period_end = 1'b0;
        cyc();
        cyc();
        chk("reset_pwm_en", 32'(pwm_en), 32'd0);
        chk("reset_duty",   32'(duty),   32'd0);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_step",   32'(step),   32'd0);
        rst_n = 1'b1;
        cyc();

        // T1: hold=2, four steps, no loop.
        write(2'd0, 8'd10); write(2'd1, 8'd20); write(2'd2, 8'd30); write(2'd3, 8'd40);
        last_idx = 2'd3; hold = 8'd2; loop = 1'b0;
        foreach (exp_duty_q[i]) ; // no-op
        exp_duty_q.push_back(8'd10); exp_duty_q.push_back(8'd10);
        exp_duty_q.push_back(8'd20); exp_duty_q.push_back(8'd20);
        exp_duty_q.push_back(8'd30); exp_duty_q.push_back(8'd30);
        exp_duty_q.push_back(8'd40); exp_duty_q.push_back(8'd40);
        exp_done_q.push_back(8);
        period_end = 1'b1;  // ignored while idle
        cyc();
        period_end = 1'b0;
        start_pulse();
        chk("t1_busy",   32'(busy),   32'd1);
        chk("t1_pwm_en", 32'(pwm_en), 32'd1);
        chk("t1_duty0",  32'(duty),   32'd10);
        chk("t1_step0",  32'(step),   32'd0);
        for (int i = 0; i < 7; i++) pulse(1'b0);
        period_end = 1'b1;
        cyc();
        period_end = 1'b0;
        chk("t1_fin_done",   32'(done),   32'd1);
        chk("t1_fin_pwm_en", 32'(pwm_en), 32'd0);
        chk("t1_fin_duty",   32'(duty),   32'd0);
        chk("t1_fin_busy",   32'(busy),   32'd0);
        cyc();
        chk("t1_idle_done", 32'(done), 32'd0);
        chk("t1_idle_duty", 32'(duty), 32'd0);

        // T2: loop, hold=1, stop coinciding with period_end.
        loop = 1'b1; hold = 8'd1;
        exp_duty_q.push_back(8'd10); exp_duty_q.push_back(8'd20);
        exp_duty_q.push_back(8'd30); exp_duty_q.push_back(8'd40);
        exp_duty_q.push_back(8'd10); exp_duty_q.push_back(8'd20);
        exp_duty_q.push_back(8'd30);
        start_pulse();
        for (int i = 0; i < 6; i++) pulse(1'b0);
        chk("t2_step_wrap", 32'(step), 32'd2);
        period_end = 1'b1;
        stop       = 1'b1;
        cyc();
        period_end = 1'b0;
        stop       = 1'b0;
        chk("t2_stop_busy", 32'(busy), 32'd0);
        chk("t2_stop_duty", 32'(duty), 32'd0);
        chk("t2_stop_done", 32'(done), 32'd0);
        cyc();
        chk("t2_stop_done2", 32'(done), 32'd0);

        // T3: external start edge qualification.
        loop = 1'b0; hold = 8'd1; last_idx = 2'd1;
        ext_start_en = 1'b0; start_ext = 1'b1;
        cyc(); cyc();
        chk("t3_no_start_disabled", 32'(busy), 32'd0);
        start_ext = 1'b0;
        cyc();
        exp_duty_q.push_back(8'd10); exp_duty_q.push_back(8'd20);
        exp_done_q.push_back(2);
        ext_start_en = 1'b1; start_ext = 1'b1;
        cyc();
        chk("t3_ext_start_busy", 32'(busy), 32'd1);
        pulse(1'b0);
        pulse(1'b0);
        cyc(); cyc(); cyc();
        chk("t3_no_retrigger", 32'(busy), 32'd0);
        start_ext = 1'b0; ext_start_en = 1'b0;
        cyc();

        // T4: hold=0 behaves as hold=1; single-step sequence.
        hold = 8'd0; last_idx = 2'd3;
        exp_duty_q.push_back(8'd10); exp_duty_q.push_back(8'd20);
        exp_duty_q.push_back(8'd30); exp_duty_q.push_back(8'd40);
        exp_done_q.push_back(4);
        start_pulse();
        for (int i = 0; i < 4; i++) pulse(1'b0);
        chk("t4_hold0_end_busy", 32'(busy), 32'd0);
        last_idx = 2'd0;
        exp_duty_q.push_back(8'd10);
        exp_done_q.push_back(1);
        start_pulse();
        pulse(1'b0);
        chk("t4_single_end_busy", 32'(busy), 32'd0);

        // T5: write to the current step only shows on its next visit.
        hold = 8'd1; last_idx = 2'd3; loop = 1'b1;
        exp_duty_q.push_back(8'd10); exp_duty_q.push_back(8'd20);
        exp_duty_q.push_back(8'd30); exp_duty_q.push_back(8'd40);
        exp_duty_q.push_back(8'd10); exp_duty_q.push_back(8'd99);
        start_pulse();
        pulse(1'b0);
        write(2'd1, 8'd99);
        chk("t5_step1",       32'(step), 32'd1);
        chk("t5_duty_stays",  32'(duty), 32'd20);
        for (int i = 0; i < 4; i++) pulse(1'b0);
        chk("t5_duty_new",    32'(duty), 32'd99);
        pulse(1'b0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t5_stop_busy", 32'(busy), 32'd0);

        // T6: start ignored while running; async reset mid-run clears the table.
        exp_duty_q.push_back(8'd10);
        start_pulse();
        pulse(1'b0);
        start_pulse();
        chk("t6_restart_ignored_step", 32'(step), 32'd1);
        chk("t6_restart_ignored_busy", 32'(busy), 32'd1);
        chk("t6_restart_ignored_duty", 32'(duty), 32'd99);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pwm_en", 32'(pwm_en), 32'd0);
        chk("t6_rst_duty",   32'(duty),   32'd0);
        chk("t6_rst_busy",   32'(busy),   32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        start_pulse();
        chk("t6_after_rst_busy", 32'(busy), 32'd1);
        chk("t6_after_rst_duty", 32'(duty), 32'd0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();

        chk("scoreboard_duty_drained", 32'(exp_duty_q.size()), 32'd0);
        chk("scoreboard_done_drained", 32'(exp_done_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
